// File: rtl/note_lane_scheduler.sv
// Frame sequencer for the note lane: on each tick, snapshots the note sequences and
// plots one 4x4 square per slot (red, yellow or erase) through the shared VGA plot path.
module note_lane_scheduler #(
   parameter int unsigned NUM_SLOTS  = 10,
   parameter int unsigned SLOT_PITCH = 8,
   parameter int unsigned LANE_X0    = 8,
   parameter int unsigned LANE_Y     = 60
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 tick,
   input  logic [NUM_SLOTS-1:0] red_seq,
   input  logic [NUM_SLOTS-1:0] yellow_seq,
   output logic [7:0]           x,
   output logic [6:0]           y,
   output logic [2:0]           colour,
   output logic                 plot,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 overrun
);

   localparam int unsigned SlotW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam logic [SlotW-1:0] LastSlot = SlotW'(NUM_SLOTS - 1);

   typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

   state_e               state_q;
   logic [SlotW-1:0]     slot_q;
   logic [3:0]           pix_q;
   logic                 pending_q;
   logic                 overrun_q;
   logic [NUM_SLOTS-1:0] red_snap_q;
   logic [NUM_SLOTS-1:0] yellow_snap_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= StIdle;
         slot_q        <= '0;
         pix_q         <= '0;
         pending_q     <= 1'b0;
         overrun_q     <= 1'b0;
         red_snap_q    <= '0;
         yellow_snap_q <= '0;
      end else begin
         overrun_q <= 1'b0;
         case (state_q)
            StIdle: begin
               // A tick queued on the last DONE cycle starts the frame from here.
               if (tick || pending_q) begin
                  red_snap_q    <= red_seq;
                  yellow_snap_q <= yellow_seq;
                  slot_q        <= '0;
                  pix_q         <= '0;
                  pending_q     <= 1'b0;
                  state_q       <= StDraw;
               end
            end
            StDraw: begin
               pix_q <= pix_q + 4'd1;
               if (pix_q == 4'd15) begin
                  if (slot_q == LastSlot) begin
                     state_q <= StDone;
                  end else begin
                     slot_q <= slot_q + 1'b1;
                  end
               end
               if (tick) begin
                  if (pending_q) begin
                     overrun_q <= 1'b1;
                  end else begin
                     pending_q <= 1'b1;
                  end
               end
            end
            StDone: begin
               if (pending_q) begin
                  red_snap_q    <= red_seq;
                  yellow_snap_q <= yellow_seq;
                  slot_q        <= '0;
                  pix_q         <= '0;
                  state_q       <= StDraw;
               end else begin
                  state_q <= StIdle;
               end
               pending_q <= tick;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   logic [7:0] slot_x;

   always_comb begin
      plot       = (state_q == StDraw);
      busy       = (state_q != StIdle);
      frame_done = (state_q == StDone);
      overrun    = overrun_q;
      slot_x     = 8'(LANE_X0) + 8'(slot_q) * 8'(SLOT_PITCH);
      x          = 8'd0;
      y          = 7'd0;
      colour     = 3'b000;
      if (plot) begin
         x = slot_x + {6'd0, pix_q[1:0]};
         y = 7'(LANE_Y) + {5'd0, pix_q[3:2]};
         if (red_snap_q[slot_q]) begin
            colour = 3'b100;
         end else if (yellow_snap_q[slot_q]) begin
            colour = 3'b110;
         end
      end
   end

endmodule

// File: tb/tb_note_lane_scheduler.sv
// Randomized bench for note_lane_scheduler against a frame-timeline reference model.
module tb_note_lane_scheduler;

   localparam int NS     = 10;
   localparam int PITCH  = 8;
   localparam int X0     = 8;
   localparam int Y0     = 60;
   localparam int FRAME  = 16 * NS;

   logic          clk = 1'b0;
   logic          resetn;
   logic          tick;
   logic [NS-1:0] red_seq;
   logic [NS-1:0] yellow_seq;
   logic [7:0]    x;
   logic [6:0]    y;
   logic [2:0]    colour;
   logic          plot;
   logic          busy;
   logic          frame_done;
   logic          overrun;

   note_lane_scheduler #(
      .NUM_SLOTS (NS),
      .SLOT_PITCH(PITCH),
      .LANE_X0   (X0),
      .LANE_Y    (Y0)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .tick      (tick),
      .red_seq   (red_seq),
      .yellow_seq(yellow_seq),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .plot      (plot),
      .busy      (busy),
      .frame_done(frame_done),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
      end
   endtask

   // Model: a frame is the time window following the edge that started it.
   int            e        = 0;
   int            m_start  = 0;
   int            m_drop   = -1;
   bit            m_active = 1'b0;
   bit            m_pend   = 1'b0;
   logic [NS-1:0] m_red    = '0;
   logic [NS-1:0] m_yel    = '0;

   task automatic model_reset();
      m_active = 1'b0;
      m_pend   = 1'b0;
      m_drop   = -1;
   endtask

   task automatic model_edge(input logic tk, input logic [NS-1:0] r, input logic [NS-1:0] yl);
      e++;
      if (m_active && (e - 1 - m_start) == FRAME) begin
         if (m_pend) begin
            m_start = e;
            m_red   = r;
            m_yel   = yl;
         end else begin
            m_active = 1'b0;
         end
         m_pend = tk;
      end else if (m_active) begin
         if (tk) begin
            if (m_pend) m_drop = e;
            else        m_pend = 1'b1;
         end
      end else if (tk || m_pend) begin
         m_active = 1'b1;
         m_start  = e;
         m_red    = r;
         m_yel    = yl;
         m_pend   = 1'b0;
      end
   endtask

   task automatic check_outputs();
      int d, s, p, ex, ey, ec;
      bit ep, ed;
      d  = e - m_start;
      ep = m_active && d < FRAME;
      ed = m_active && d == FRAME;
      ex = 0; ey = 0; ec = 0;
      if (ep) begin
         s  = d / 16;
         p  = d % 16;
         ex = X0 + s * PITCH + p % 4;
         ey = Y0 + p / 4;
         ec = m_red[s] ? 4 : (m_yel[s] ? 6 : 0);
      end
      check("plot", 32'(plot), 32'(ep));
      check("busy", 32'(busy), 32'(m_active));
      check("frame_done", 32'(frame_done), 32'(ed));
      check("overrun", 32'(overrun), 32'(m_drop == e));
      check("x", 32'(x), 32'(ex));
      check("y", 32'(y), 32'(ey));
      check("colour", 32'(colour), 32'(ec));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_x"}, 32'(x), 0);
      check({tag, "_y"}, 32'(y), 0);
      check({tag, "_colour"}, 32'(colour), 0);
      check({tag, "_flags"}, 32'({plot, busy, frame_done, overrun}), 0);
   endtask

   initial begin
      int rate;
      resetn     = 1'b0;
      tick       = 1'b0;
      red_seq    = '0;
      yellow_seq = '0;
      repeat (4) begin
         @(negedge clk);
         tick = ~tick;
         #1 check_zero("in_reset");
      end
      @(negedge clk);
      tick   = 1'b0;
      resetn = 1'b1;
      model_reset();

      // Directed first frame: only slot 0 red.
      red_seq = NS'(1);
      tick    = 1'b1;
      @(posedge clk);
      model_edge(tick, red_seq, yellow_seq);
      @(negedge clk);
      check_outputs();
      tick = 1'b0;
      repeat (FRAME + 4) begin
         @(posedge clk);
         model_edge(tick, red_seq, yellow_seq);
         @(negedge clk);
         check_outputs();
      end

      for (int cyc = 0; cyc < 6000; cyc++) begin
         rate       = (cyc < 2000) ? 200 : ((cyc < 4000) ? 25 : 6);
         tick       = ($urandom_range(rate - 1) == 0);
         red_seq    = NS'($urandom);
         yellow_seq = NS'($urandom);
         if ($urandom_range(599) == 0) begin
            resetn = 1'b0;
            #1 check_zero("async_rst");
            model_reset();
            @(posedge clk);
            @(negedge clk);
            check_zero("rst_hold");
            resetn = 1'b1;
            tick   = 1'b1;
         end
         @(posedge clk);
         model_edge(tick, red_seq, yellow_seq);
         @(negedge clk);
         check_outputs();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
